mem_access_ctrl: RTL and testbench

- Load/store sequencer between the execute stage and the 8-bit data memory.
- Accepts one load or store request at a time over a valid/ready handshake.
- Drives the memory's Rm/Wm/address/RegVal with a guaranteed address-setup cycle before any strobe, because the memory is level-sensitive.
- Registers load data and returns it to the register-file writeback port; out-of-range addresses are flagged rather than issued.

---
 rtl/mem_access_ctrl.sv | 94 +++++++++
 tb/tb_mem_access_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a level-sensitive 8-bit data memory.
// Guarantees one address-setup cycle before each single-cycle Rm/Wm strobe.
module mem_access_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 36,
   parameter int unsigned RD_W      = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_load,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [RD_W-1:0]   req_rd,
   output logic              Rm,
   output logic              Wm,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] RegVal,
   input  logic [DATA_W-1:0] Data_out,
   output logic              wb_valid,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              fault,
   output logic [7:0]        ops_done
);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, FAULT} state_t;

   state_t          state, state_next;
   logic            accept_c;
   logic            in_range_c;
   logic            load_q;
   logic [RD_W-1:0] rd_q;

   // Next-state logic; addresses at or beyond MEM_DEPTH are never issued
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      in_range_c = (req_addr < ADDR_W'(MEM_DEPTH));
      case (state)
         IDLE: begin
            accept_c = req_valid;
            if (req_valid) state_next = in_range_c ? SETUP : FAULT;
         end
         SETUP:   state_next = ACCESS;
         ACCESS:  state_next = load_q ? RESP : IDLE;
         RESP:    state_next = IDLE;
         FAULT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes and pulses are decoded from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         Rm        <= 1'b0;
         Wm        <= 1'b0;
         address   <= '0;
         RegVal    <= '0;
         load_q    <= 1'b0;
         rd_q      <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         fault     <= 1'b0;
         ops_done  <= '0;
      end else begin
         state     <= state_next;
         req_ready <= (state_next == IDLE);
         Rm        <= (state_next == ACCESS) && load_q;
         Wm        <= (state_next == ACCESS) && !load_q;
         wb_valid  <= (state_next == RESP);
         fault     <= (state_next == FAULT);
         if (accept_c) begin
            load_q  <= req_load;
            address <= req_addr;
            RegVal  <= req_wdata;
            rd_q    <= req_rd;
         end
         if (state == ACCESS) begin
            ops_done <= ops_done + 8'd1;
            if (load_q) begin
               wb_data <= Data_out;
               wb_rd   <= rd_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: memory model, strobe/writeback
// scoreboard, and per-feature latency and counter checks.
module tb_mem_access_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_load = 1'b0;
   logic [7:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic [2:0] req_rd = '0;
   logic       Rm, Wm;
   logic [7:0] address, RegVal, Data_out;
   logic       wb_valid;
   logic [2:0] wb_rd;
   logic [7:0] wb_data;
   logic       fault;
   logic [7:0] ops_done;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } pair_t;

   pair_t      st_q[$];
   pair_t      wb_q[$];
   logic [7:0] ld_q[$];
   logic [7:0] ref_mem[64];
   logic [7:0] mem[64];
   int         fault_pend = 0;
   int         exp_ops = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   logic [7:0] prev_addr = '0;

   mem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .Rm(Rm), .Wm(Wm), .address(address), .RegVal(RegVal), .Data_out(Data_out),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .fault(fault), .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Level-sensitive memory: combinational read, write on the edge ending a Wm cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 7 + 3);
      end else if (Wm) begin
         mem[address[5:0]] <= RegVal;
      end
   end

   assign Data_out = (address < 8'd36) ? mem[address[5:0]] : 8'h00;

   task automatic monitor();
      pair_t p;
      logic [7:0] a;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (Rm || Wm) begin
               n_cmp++;
               if (Rm && Wm) begin
                  n_err++; $display("FAIL strobe_both: Rm=%0b Wm=%0b required not both", Rm, Wm);
               end
               n_cmp++;
               if (address !== prev_addr) begin
                  n_err++; $display("FAIL addr_stable: address=%0d setup=%0d", address, prev_addr);
               end
            end
            if (Wm) begin
               n_cmp++;
               if (st_q.size() == 0) begin
                  n_err++; $display("FAIL unexpected_wm: address=%0d required no write", address);
               end else begin
                  p = st_q.pop_front();
                  if (address !== p.a || RegVal !== p.d) begin
                     n_err++;
                     $display("FAIL store_issue: addr=%0d data=%h required addr=%0d data=%h", address, RegVal, p.a, p.d);
                  end
               end
            end
            if (Rm) begin
               n_cmp++;
               if (ld_q.size() == 0) begin
                  n_err++; $display("FAIL unexpected_rm: address=%0d required no read", address);
               end else begin
                  a = ld_q.pop_front();
                  if (address !== a) begin
                     n_err++; $display("FAIL load_issue: addr=%0d required %0d", address, a);
                  end
               end
            end
            if (wb_valid) begin
               n_cmp++;
               if (wb_q.size() == 0) begin
                  n_err++; $display("FAIL unexpected_wb: rd=%0d required no writeback", wb_rd);
               end else begin
                  p = wb_q.pop_front();
                  if (wb_rd !== p.a[2:0] || wb_data !== p.d) begin
                     n_err++;
                     $display("FAIL writeback: rd=%0d data=%h required rd=%0d data=%h", wb_rd, wb_data, p.a[2:0], p.d);
                  end
               end
            end
            if (fault) begin
               n_cmp++;
               if (fault_pend == 0) begin
                  n_err++; $display("FAIL unexpected_fault: fault=1 required 0");
               end else begin
                  fault_pend--;
               end
            end
         end
         prev_addr = address;
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req_valid = 1'b0;
      st_q.delete(); wb_q.delete(); ld_q.delete();
      fault_pend = 0;
      exp_ops = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 7 + 3);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Present a request, wait for acceptance, log expectations; returns at the
   // negedge of the first cycle after the accepting edge.
   task automatic do_req(input bit ld, input logic [7:0] addr, input logic [7:0] wd,
                         input logic [2:0] rd, input bit keep, output int acc);
      int budget = 0;
      pair_t p;
      req_valid = 1'b1; req_load = ld; req_addr = addr; req_wdata = wd; req_rd = rd;
      while (!req_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (!req_ready) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: req_ready=0 required 1 within 20 cycles");
      end
      acc = cyc + 1;
      if (addr >= 8'd36) begin
         fault_pend++;
      end else begin
         exp_ops++;
         if (ld) begin
            ld_q.push_back(addr);
            p.a = {5'd0, rd}; p.d = ref_mem[addr[5:0]];
            wb_q.push_back(p);
         end else begin
            p.a = addr; p.d = wd;
            st_q.push_back(p);
            ref_mem[addr[5:0]] = wd;
         end
      end
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_ready(input int acc, output int lat);
      int budget = 0;
      while (!req_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (!req_ready) begin
         n_cmp++; n_err++;
         $display("FAIL ready_timeout: req_ready=0 required 1 within 20 cycles");
      end
      lat = cyc - acc;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({Rm, Wm, wb_valid, fault} !== 4'b0 || address !== 8'd0 || RegVal !== 8'd0 ||
          wb_rd !== 3'd0 || wb_data !== 8'd0 || ops_done !== 8'd0) begin
         n_err++;
         $display("FAIL reset_values: Rm=%0b Wm=%0b wbv=%0b flt=%0b addr=%0d rv=%0d rd=%0d wd=%0d ops=%0d required all 0",
                  Rm, Wm, wb_valid, fault, address, RegVal, wb_rd, wb_data, ops_done);
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready: req_ready=%0b required 1", req_ready);
      end
   endtask

   task automatic test_store();
      int acc, lat;
      do_req(1'b0, 8'd5, 8'hA7, 3'd0, 1'b0, acc);
      n_cmp++;
      if (address !== 8'd5 || Wm !== 1'b0 || Rm !== 1'b0) begin
         n_err++; $display("FAIL store_setup: addr=%0d Wm=%0b Rm=%0b required 5 0 0", address, Wm, Rm);
      end
      @(negedge clk);
      n_cmp++;
      if (Wm !== 1'b1 || RegVal !== 8'hA7) begin
         n_err++; $display("FAIL store_access: Wm=%0b RegVal=%h required 1 a7", Wm, RegVal);
      end
      wait_ready(acc, lat);
      n_cmp++;
      if (lat != 2) begin
         n_err++; $display("FAIL store_latency: %0d required 2", lat);
      end
      n_cmp++;
      if (ops_done !== 8'(exp_ops)) begin
         n_err++; $display("FAIL store_ops: ops_done=%0d required %0d", ops_done, exp_ops);
      end
   endtask

   task automatic test_load();
      int acc, lat;
      do_req(1'b1, 8'd5, 8'h00, 3'd3, 1'b0, acc);
      @(negedge clk);
      n_cmp++;
      if (Rm !== 1'b1 || Wm !== 1'b0) begin
         n_err++; $display("FAIL load_access: Rm=%0b Wm=%0b required 1 0", Rm, Wm);
      end
      @(negedge clk);
      n_cmp++;
      if (Rm !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 8'hA7) begin
         n_err++;
         $display("FAIL load_resp: Rm=%0b wbv=%0b rd=%0d data=%h required 0 1 3 a7", Rm, wb_valid, wb_rd, wb_data);
      end
      wait_ready(acc, lat);
      n_cmp++;
      if (lat != 3) begin
         n_err++; $display("FAIL load_latency: %0d required 3", lat);
      end
      n_cmp++;
      if (wb_valid !== 1'b0 || wb_rd !== 3'd3 || wb_data !== 8'hA7) begin
         n_err++; $display("FAIL wb_hold: wbv=%0b rd=%0d data=%h required 0 3 a7", wb_valid, wb_rd, wb_data);
      end
   endtask

   task automatic test_fault();
      int acc, lat;
      int ops0 = exp_ops;
      do_req(1'b0, 8'd36, 8'h11, 3'd0, 1'b0, acc);
      n_cmp++;
      if (fault !== 1'b1) begin
         n_err++; $display("FAIL fault_36: fault=%0b required 1", fault);
      end
      wait_ready(acc, lat);
      n_cmp++;
      if (lat != 1) begin
         n_err++; $display("FAIL fault_latency: %0d required 1", lat);
      end
      do_req(1'b1, 8'd255, 8'h00, 3'd6, 1'b0, acc);
      n_cmp++;
      if (fault !== 1'b1) begin
         n_err++; $display("FAIL fault_255: fault=%0b required 1", fault);
      end
      wait_ready(acc, lat);
      n_cmp++;
      if (fault !== 1'b0 || ops_done !== 8'(ops0)) begin
         n_err++; $display("FAIL fault_after: fault=%0b ops=%0d required 0 %0d", fault, ops_done, ops0);
      end
      do_req(1'b0, 8'd35, 8'h3C, 3'd0, 1'b0, acc);
      wait_ready(acc, lat);
      n_cmp++;
      if (lat != 2 || ops_done !== 8'(ops0 + 1)) begin
         n_err++; $display("FAIL store_35: lat=%0d ops=%0d required 2 %0d", lat, ops_done, ops0 + 1);
      end
      do_req(1'b1, 8'd35, 8'h00, 3'd1, 1'b0, acc);
      wait_ready(acc, lat);
   endtask

   task automatic test_back_to_back();
      int acc, prev_acc, lat;
      bit prev_ld = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bit ld = i[0];
         do_req(ld, 8'(10 + i / 2), 8'(8'h40 + i), 3'(i), 1'b1, acc);
         if (i > 0) begin
            n_cmp++;
            if (acc - prev_acc != (prev_ld ? 4 : 3)) begin
               n_err++;
               $display("FAIL b2b_gap: req %0d gap=%0d required %0d", i, acc - prev_acc, prev_ld ? 4 : 3);
            end
         end
         prev_acc = acc;
         prev_ld = ld;
      end
      req_valid = 1'b0;
      wait_ready(acc, lat);
      n_cmp++;
      if (ops_done !== 8'(exp_ops)) begin
         n_err++; $display("FAIL b2b_ops: ops_done=%0d required %0d", ops_done, exp_ops);
      end
   endtask

   task automatic test_reset_mid();
      int acc;
      do_req(1'b0, 8'd7, 8'h5C, 3'd0, 1'b0, acc);
      @(negedge clk);
      n_cmp++;
      if (Wm !== 1'b1) begin
         n_err++; $display("FAIL mid_wm_before: Wm=%0b required 1", Wm);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (Wm !== 1'b0 || Rm !== 1'b0 || ops_done !== 8'd0 || wb_valid !== 1'b0 || fault !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: Wm=%0b Rm=%0b ops=%0d wbv=%0b flt=%0b required all 0", Wm, Rm, ops_done, wb_valid, fault);
      end
      apply_reset();
      n_cmp++;
      if (req_ready !== 1'b1 || ops_done !== 8'd0) begin
         n_err++; $display("FAIL mid_release: ready=%0b ops=%0d required 1 0", req_ready, ops_done);
      end
      do_req(1'b1, 8'd7, 8'h00, 3'd2, 1'b0, acc);
      wait_ready(acc, acc);
   endtask

   task automatic test_wrap();
      int acc, lat;
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         do_req(1'b0, 8'(i % 36), 8'(i), 3'd0, 1'b0, acc);
         wait_ready(acc, lat);
      end
      n_cmp++;
      if (ops_done !== 8'd0) begin
         n_err++; $display("FAIL wrap_zero: ops_done=%0d required 0", ops_done);
      end
      do_req(1'b0, 8'd0, 8'h99, 3'd0, 1'b0, acc);
      wait_ready(acc, lat);
      n_cmp++;
      if (ops_done !== 8'd1) begin
         n_err++; $display("FAIL wrap_one: ops_done=%0d required 1", ops_done);
      end
      do_req(1'b1, 8'd0, 8'h00, 3'd7, 1'b0, acc);
      wait_ready(acc, lat);
      do_req(1'b1, 8'd20, 8'h00, 3'd4, 1'b0, acc);
      wait_ready(acc, lat);
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_store();
      test_load();
      test_fault();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (st_q.size() != 0 || ld_q.size() != 0 || wb_q.size() != 0 || fault_pend != 0) begin
         n_err++;
         $display("FAIL drain: st=%0d ld=%0d wb=%0d faults=%0d required all 0",
                  st_q.size(), ld_q.size(), wb_q.size(), fault_pend);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
